bt656_timing_decoder: RTL and testbench

Decodes a raw 8-bit BT.656 byte stream (one byte per pixel clock) into 16-bit pixel words with frame/line markers for the video receiver. Locates SAV/EAV timing reference codes, validates their protection bits, tracks field/vertical blanking, counts pixels and lines against the configured active geometry, and reports sticky framing errors. Sits between the camera/`bt656_stream_gen` pins and the receiver inside `video_ctrl_top`, in the pixel-clock domain.

---
 rtl/bt656_timing_decoder_if.sv | 29 ++
 rtl/bt656_timing_decoder.sv | 132 +++++++++++++
 tb/tb_bt656_timing_decoder.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/bt656_timing_decoder_if.sv
// Pixel-clock bundle between the BT.656 byte source and the video receiver.
// The master drives the byte stream and control; the decoder (slave) returns pixel words.
interface bt656_timing_decoder_if #(
  parameter int CNT_W = 11
);
  logic             en_i;
  logic [7:0]       data_i;
  logic             err_clr_i;
  logic [15:0]      pix_data_o;
  logic             pix_valid_o;
  logic             sof_o;
  logic             eol_o;
  logic             field_o;
  logic [CNT_W-1:0] pix_cnt_o;
  logic [CNT_W-1:0] line_cnt_o;
  logic [3:0]       err_o;

  modport master (
    output en_i, data_i, err_clr_i,
    input  pix_data_o, pix_valid_o, sof_o, eol_o, field_o,
           pix_cnt_o, line_cnt_o, err_o
  );

  modport slave (
    input  en_i, data_i, err_clr_i,
    output pix_data_o, pix_valid_o, sof_o, eol_o, field_o,
           pix_cnt_o, line_cnt_o, err_o
  );
endinterface

// File: rtl/bt656_timing_decoder.sv
// BT.656 byte stream to 16-bit pixel words with SOF/EOL markers, field and sticky framing errors.
// state  | meaning
// SEEK   | waiting for a valid timing code with V=1 (vertical blanking)
// BLANK  | between lines; waiting for an SAV with V=0
// ACTIVE | pairing active-video bytes into words until the next EAV
module bt656_timing_decoder #(
  parameter int ACT_PIX   = 640,
  parameter int ACT_LINES = 480,
  parameter int CNT_W     = 11
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  bt656_timing_decoder_if.slave bus
);

  typedef enum logic [1:0] {SEEK, BLANK, ACTIVE} state_t;

  localparam logic [CNT_W:0]   PIX_MAX  = (CNT_W+1)'(ACT_PIX);
  localparam logic [CNT_W-1:0] PIX_LAST = CNT_W'(ACT_PIX - 1);
  localparam logic [CNT_W-1:0] LINES    = CNT_W'(ACT_LINES);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  state_t     state;
  logic [7:0] d3, d2, d1, d0;
  logic [7:0] hi_byte;
  logic       phase;
  logic       vblank;
  logic       sof_arm;

  logic           hdr, xy_ok, code_ok, f_bit, v_bit, h_bit;
  logic [CNT_W:0] words_done;
  logic [3:0]     err_set;

  always_comb begin
    f_bit   = d0[6];
    v_bit   = d0[5];
    h_bit   = d0[4];
    hdr     = (d3 == 8'hFF) && (d2 == 8'h00) && (d1 == 8'h00);
    xy_ok   = d0[7] && (d0[3] == (v_bit ^ h_bit)) && (d0[2] == (f_bit ^ h_bit)) &&
              (d0[1] == (f_bit ^ v_bit)) && (d0[0] == (f_bit ^ v_bit ^ h_bit));
    code_ok = bus.en_i && hdr && xy_ok;
    // a word strobed last cycle is not yet reflected in pix_cnt_o
    words_done = {1'b0, bus.pix_cnt_o} + {{CNT_W{1'b0}}, bus.pix_valid_o};
    err_set    = 4'h0;
    err_set[0] = bus.en_i && hdr && !xy_ok;
    if (bus.en_i && (state == ACTIVE) && (d0 == 8'hFF))
      err_set[1] = phase || (words_done < PIX_MAX);
    if (bus.en_i && (state == ACTIVE) && phase && (d0 != 8'hFF))
      err_set[2] = ({1'b0, bus.pix_cnt_o} >= PIX_MAX);
    if (code_ok && (state == BLANK) && v_bit && !vblank)
      err_set[3] = (bus.line_cnt_o != LINES);
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state           <= SEEK;
      {d3, d2, d1, d0} <= 32'h0;
      hi_byte         <= 8'h00;
      phase           <= 1'b0;
      vblank          <= 1'b0;
      sof_arm         <= 1'b0;
      bus.pix_data_o  <= 16'h0000;
      bus.pix_valid_o <= 1'b0;
      bus.sof_o       <= 1'b0;
      bus.eol_o       <= 1'b0;
      bus.field_o     <= 1'b0;
      bus.pix_cnt_o   <= '0;
      bus.line_cnt_o  <= '0;
      bus.err_o       <= 4'h0;
    end else begin
      {d3, d2, d1, d0} <= {d2, d1, d0, bus.data_i};
      bus.pix_valid_o  <= 1'b0;
      bus.sof_o        <= 1'b0;
      bus.eol_o        <= 1'b0;
      bus.err_o        <= (bus.err_clr_i ? 4'h0 : bus.err_o) | err_set;
      if (bus.pix_valid_o)
        bus.pix_cnt_o <= bus.pix_cnt_o + ONE;

      if (!bus.en_i) begin
        state   <= SEEK;
        phase   <= 1'b0;
        sof_arm <= 1'b0;
      end else begin
        if (code_ok) begin
          vblank <= v_bit;
          if (!h_bit)
            bus.field_o <= f_bit;
        end
        case (state)
          SEEK: begin
            if (code_ok && v_bit)
              state <= BLANK;
          end
          BLANK: begin
            if (code_ok && !h_bit && !v_bit) begin
              state         <= ACTIVE;
              phase         <= 1'b0;
              bus.pix_cnt_o <= '0;
              if (vblank) begin
                sof_arm        <= 1'b1;
                bus.line_cnt_o <= '0;
              end
            end
          end
          ACTIVE: begin
            if (d0 == 8'hFF) begin
              // even phase: EAV start; odd phase: pending half word is discarded
              state <= BLANK;
              phase <= 1'b0;
              if (bus.line_cnt_o != {CNT_W{1'b1}})
                bus.line_cnt_o <= bus.line_cnt_o + ONE;
            end else if (phase) begin
              phase <= 1'b0;
              if ({1'b0, bus.pix_cnt_o} < PIX_MAX) begin
                bus.pix_valid_o <= 1'b1;
                bus.pix_data_o  <= {hi_byte, d0};
                bus.sof_o       <= sof_arm;
                bus.eol_o       <= (bus.pix_cnt_o == PIX_LAST);
                sof_arm         <= 1'b0;
              end
            end else begin
              hi_byte <= d0;
              phase   <= 1'b1;
            end
          end
          default: state <= SEEK;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bt656_timing_decoder.sv
// Directed bench for bt656_timing_decoder: small frames (4 words x 2 lines) with hand-derived results.
module tb_bt656_timing_decoder;
  localparam int ACT_PIX   = 4;
  localparam int ACT_LINES = 2;
  localparam int CNT_W     = 11;

  logic ACLK = 1'b0;
  logic ARESETn = 1'b0;
  always #5 ACLK = ~ACLK;

  bt656_timing_decoder_if #(.CNT_W(CNT_W)) bus ();

  bt656_timing_decoder #(
    .ACT_PIX  (ACT_PIX),
    .ACT_LINES(ACT_LINES),
    .CNT_W    (CNT_W)
  ) dut (
    .ACLK   (ACLK),
    .ARESETn(ARESETn),
    .bus    (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0]      wq[$];
  logic             sq[$];
  logic             eq[$];
  logic [CNT_W-1:0] cq[$];
  int n_str = 0, n_sof = 0, n_eol = 0;

  always @(negedge ACLK) begin
    if (bus.pix_valid_o === 1'b1) begin
      wq.push_back(bus.pix_data_o);
      sq.push_back(bus.sof_o);
      eq.push_back(bus.eol_o);
      cq.push_back(bus.pix_cnt_o);
      n_str++;
      if (bus.sof_o === 1'b1) n_sof++;
      if (bus.eol_o === 1'b1) n_eol++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clr_q();
    wq.delete(); sq.delete(); eq.delete(); cq.delete();
    n_str = 0; n_sof = 0; n_eol = 0;
  endtask

  task automatic put(input logic [7:0] b);
    @(negedge ACLK);
    bus.data_i = b;
  endtask

  task automatic code(input logic [7:0] xy);
    put(8'hFF); put(8'h00); put(8'h00); put(xy);
  endtask

  task automatic blank(input int n);
    for (int i = 0; i < n; i++) begin
      put(8'h80); put(8'h10);
    end
  endtask

  task automatic line(input logic [7:0] sav, input logic [7:0] eav, input int nbytes);
    blank(2);
    code(sav);
    for (int i = 0; i < nbytes; i++) put(8'((i + 1) * 16));
    code(eav);
  endtask

  task automatic frame(input bit f, input int n1, input int n2, input bit bad_sav2);
    logic [7:0] sav0, eav0, sav1, eav1;
    sav0 = f ? 8'hC7 : 8'h80;
    eav0 = f ? 8'hDA : 8'h9D;
    sav1 = f ? 8'hEC : 8'hAB;
    eav1 = f ? 8'hF1 : 8'hB6;
    code(eav1);
    blank(2);
    code(sav1);
    line(sav0, eav0, n1);
    line(bad_sav2 ? (sav0 ^ 8'h01) : sav0, eav0, n2);
    code(eav1);
    blank(3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time %0t exceeded limit 200000", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.en_i = 1'b1;
    bus.data_i = 8'h00;
    bus.err_clr_i = 1'b0;
    #1;
    chk("rst_data", bus.pix_data_o, 0);
    chk("rst_flags", {bus.pix_valid_o, bus.sof_o, bus.eol_o, bus.field_o}, 0);
    chk("rst_cnts", {bus.pix_cnt_o, bus.line_cnt_o, bus.err_o}, 0);
    repeat (3) @(negedge ACLK);
    ARESETn = 1'b1;
    repeat (3) @(negedge ACLK);
    chk("post_rst_err", bus.err_o, 0);

    // nominal frame
    frame(1'b0, 8, 8, 1'b0);
    chk("t1_strobes", n_str, 8);
    chk("t1_word0", wq[0], 16'h1020);
    chk("t1_sof0", sq[0], 1);
    chk("t1_sof_cnt", n_sof, 1);
    chk("t1_word3", wq[3], 16'h7080);
    chk("t1_eol3", eq[3], 1);
    chk("t1_eol7", eq[7], 1);
    chk("t1_eol_cnt", n_eol, 2);
    chk("t1_cnt3", cq[3], 3);
    chk("t1_word4", wq[4], 16'h1020);
    chk("t1_err", bus.err_o, 4'h0);
    chk("t1_lines", bus.line_cnt_o, 2);
    chk("t1_field", bus.field_o, 0);

    // parity-corrupted SAV on line 2
    clr_q();
    frame(1'b0, 8, 8, 1'b1);
    chk("t2_strobes", n_str, 4);
    chk("t2_err", bus.err_o, 4'b1001);
    chk("t2_lines", bus.line_cnt_o, 1);

    // clear coincident with a new parity error keeps only the new bit
    put(8'hFF); put(8'h00); put(8'h00); put(8'hB7);
    @(negedge ACLK);
    bus.data_i = 8'h80;
    bus.err_clr_i = 1'b1;
    @(negedge ACLK);
    bus.err_clr_i = 1'b0;
    chk("clr_coinc", bus.err_o, 4'b0001);
    bus.err_clr_i = 1'b1;
    @(negedge ACLK);
    bus.err_clr_i = 1'b0;
    chk("clr_plain", bus.err_o, 4'b0000);

    // short line then long line
    clr_q();
    frame(1'b0, 6, 10, 1'b0);
    chk("t3_strobes", n_str, 7);
    chk("t3_word2", wq[2], 16'h5060);
    chk("t3_sof_cnt", n_sof, 1);
    chk("t3_eol_cnt", n_eol, 1);
    chk("t3_eol6", eq[6], 1);
    chk("t3_cnt6", cq[6], 3);
    chk("t3_word6", wq[6], 16'h7080);
    chk("t3_err", bus.err_o, 4'b0110);
    chk("t3_lines", bus.line_cnt_o, 2);

    // enable dropped for 3 cycles mid-line
    bus.err_clr_i = 1'b1;
    @(negedge ACLK);
    bus.err_clr_i = 1'b0;
    clr_q();
    code(8'hB6); blank(2); code(8'hAB); blank(2); code(8'h80);
    put(8'h10); put(8'h20); put(8'h30); put(8'h40);
    @(negedge ACLK); bus.data_i = 8'h50; bus.en_i = 1'b0;
    put(8'h60); put(8'h70);
    @(negedge ACLK); bus.data_i = 8'h80; bus.en_i = 1'b1;
    code(8'h9D);
    line(8'h80, 8'h9D, 8);
    code(8'hB6);
    blank(3);
    chk("t4_dis_strobes", n_str, 1);
    frame(1'b0, 8, 8, 1'b0);
    chk("t4_strobes", n_str, 9);
    chk("t4_resume_sof", sq[1], 1);
    chk("t4_resume_word", wq[1], 16'h1020);
    chk("t4_err", bus.err_o, 4'h0);

    // asynchronous reset in the middle of an F=1 active line
    code(8'hB7);
    code(8'hF1); blank(2); code(8'hEC); blank(2); code(8'hC7);
    put(8'h10); put(8'h20); put(8'h30); put(8'h40); put(8'h50); put(8'h60);
    #2;
    chk("pre_rst_valid", bus.pix_valid_o, 1);
    chk("pre_rst_field", bus.field_o, 1);
    chk("pre_rst_err", bus.err_o, 4'b0001);
    ARESETn = 1'b0;
    #1;
    chk("mid_rst_data", bus.pix_data_o, 0);
    chk("mid_rst_flags", {bus.pix_valid_o, bus.sof_o, bus.eol_o, bus.field_o}, 0);
    chk("mid_rst_cnts", {bus.pix_cnt_o, bus.line_cnt_o, bus.err_o}, 0);
    clr_q();
    repeat (2) @(negedge ACLK);
    ARESETn = 1'b1;
    put(8'h70); put(8'h80);
    code(8'hDA);
    line(8'hC7, 8'hDA, 8);
    code(8'hF1);
    blank(3);
    chk("t5_quiet", n_str, 0);
    frame(1'b1, 8, 8, 1'b0);
    chk("t5_strobes", n_str, 8);
    chk("t5_sof0", sq[0], 1);
    chk("t5_word0", wq[0], 16'h1020);
    chk("t5_field", bus.field_o, 1);
    chk("t5_err", bus.err_o, 4'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
